// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, programmable almost flags,
// sticky error flags, synchronous flush and optional first-word-fall-through output.
module sync_fifo_ctrl #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     sclr,
    input  logic                     wen,
    input  logic [WIDTH-1:0]         din,
    input  logic                     ren,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     afull,
    output logic                     aempty,
    output logic [$clog2(DEPTH):0]   used,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("sync_fifo_ctrl: DEPTH must be a power of two and at least 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_chk_afull
        $error("sync_fifo_ctrl: AFULL_THRESH must be in 1..DEPTH");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH >= DEPTH)) begin : g_chk_aempty
        $error("sync_fifo_ctrl: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    used_q, used_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic             wr_ok;
    logic             rd_ok;
    logic             drained;

    // Accept decisions use the flags as they stand before the edge.
    assign wr_ok = wen & ~full_q;
    assign rd_ok = ren & ~empty_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        used_d = used_q;
        ovf_d  = ovf_q | (wen & full_q);
        udf_d  = udf_q | (ren & empty_q);
        if (sclr) begin
            wptr_d = '0;
            rptr_d = '0;
            used_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (rd_ok) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   used_d = used_q + PW'(1);
                2'b01:   used_d = used_q - PW'(1);
                default: used_d = used_q;
            endcase
        end
    end

    always_comb begin
        full_d   = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
        empty_d  = (wptr_d == rptr_d);
        afull_d  = (used_d >= AF_T);
        aempty_d = (used_d <= AE_T);
    end

    // FWFT keeps the head word registered; when the FIFO is about to run dry the
    // only candidate for the new head is the word being written this cycle.
    assign drained = (used_q == '0) || (rd_ok && (used_q == PW'(1)));

    always_comb begin
        dout_d = dout_q;
        if (!sclr) begin
            if (FWFT != 0) begin
                if (drained) begin
                    if (wr_ok) begin
                        dout_d = din;
                    end
                end else begin
                    dout_d = mem_q[rptr_d[AW-1:0]];
                end
            end else if (rd_ok) begin
                dout_d = mem_q[rptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sclr && wr_ok) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            used_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            used_q   <= used_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dout_q   <= dout_d;
        end
    end

    assign dout      = dout_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign afull     = afull_q;
    assign aempty    = aempty_q;
    assign used      = used_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock FIFO with parametrised data width and depth, programmable almost-full and almost-empty thresholds, and an occupancy count.
- Supports two read modes: standard registered read or first-word-fall-through (FWFT).
- Provides sticky overflow and underflow error flags and a synchronous flush.
- Intended for same-domain buffering between pipeline stages where a dual-clock FIFO is unnecessary.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- FWFT, 0, read mode: 0 = standard (data one cycle after ren), 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2, afull asserts when used >= this value (1..DEPTH).
- AEMPTY_THRESH, 1, aempty asserts when used <= this value (0..DEPTH-1).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- arst_n  input  1  asynchronous active-low reset.
- sclr  input  1  synchronous flush: empties FIFO and clears error flags.
- wen  input  1  write request.
- din  input  WIDTH  write data.
- ren  input  1  read request (standard) / pop acknowledge (FWFT).
- dout  output  WIDTH  read data.
- full  output  1  used == DEPTH.
- empty  output  1  no readable word at dout (FWFT) or used == 0 (standard).
- afull  output  1  used >= AFULL_THRESH.
- aempty  output  1  used <= AEMPTY_THRESH.
- used  output  $clog2(DEPTH)+1  stored word count, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (arst_n=0, asynchronous): pointers=0, used=0, empty=1, full=0, aempty=1, afull=0 (AFULL_THRESH>=1), overflow=0, underflow=0, dout=0. Memory contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is a wrap bit. full when addresses are equal and wrap bits differ; empty when pointers are equal.
- Write accept: wr_ok = wen & ~full. Read accept: rd_ok = ren & ~empty. Both are evaluated on pre-edge flag values.
- A write while full is dropped: memory and pointers are unchanged, overflow sets, and the write is NOT accepted even if rd_ok is in the same cycle.
- A read while empty is ignored: underflow sets, and dout and pointers are unchanged.
- Simultaneous wr_ok & rd_ok: both pointers advance and used is unchanged.
- used, full, empty, afull and aempty are all registered and reflect every accepted operation in the cycle after the edge. used goes +1 on write-only, -1 on read-only, and stays unchanged on both or neither.
- Standard mode (FWFT=0): on rd_ok at edge N, dout is loaded with mem[raddr] and is valid from cycle N+1. dout holds its value otherwise.
- FWFT mode (FWFT=1):
  - dout always presents the head word whenever empty=0.
  - A write into an empty FIFO at edge N gives empty=0 and dout=that word in cycle N+1.
  - rd_ok at edge N pops the head; the next word (if any) is on dout in cycle N+1.
  - dout while empty=1 is undefined and must not be checked.
- Pointer wrap: addresses roll from DEPTH-1 to 0 and the wrap bit toggles. No data loss across the wrap.
- sclr (synchronous, has priority over wen/ren in the same cycle):
  - Next state: pointers=0, used=0, empty=1, full=0, overflow=0, underflow=0.
  - dout is unchanged in standard mode.
  - Writes and reads in the sclr cycle are discarded.
- Once set, overflow and underflow stay set until sclr or reset.
- Reset asserted mid-operation: all outputs return to reset values immediately; after release, the first accepted write is stored at address 0.
- Synthesis checks required: DEPTH is a power of two, AFULL_THRESH <= DEPTH, AEMPTY_THRESH < DEPTH.

Test Plan:
- Fill/drain (WIDTH=8, DEPTH=4, FWFT=0): write 0x11,0x22,0x33,0x44 -> full=1, used=4, afull=1 after 2nd write (thresh 2). Then 4 reads -> dout 0x11..0x44, each one cycle after its ren; empty=1 after the last.
- Overflow/underflow: with the FIFO full, wen with din=0x55 -> data dropped, overflow=1, used stays 4. Drain, then ren while empty -> underflow=1, dout holds 0x44. sclr -> both flags 0.
- Simultaneous R/W: used=2, then wen&ren for 10 cycles with an incrementing pattern -> used stays 2, output order preserved, pointers wrap twice with no corruption. With full=1, wen&ren -> read accepted, write dropped, used=3, overflow=1.
- FWFT latency (FWFT=1): write 0xA5 into an empty FIFO at edge N -> empty=0 and dout=0xA5 in cycle N+1. Write 0x5A, then pulse ren -> dout=0x5A the next cycle; second ren -> empty=1.
- Flush priority: used=3, assert sclr with wen=1 and ren=1 -> next cycle used=0, empty=1. A subsequent write of 0x77 then read returns 0x77.
- Async reset mid-stream: assert arst_n=0 between clock edges while used=3 -> used=0, empty=1, dout=0 without waiting for a clock edge. After release, write 0x01 and read -> 0x01.
